main_ctrl_fsm: RTL and testbench
================================

# main_ctrl_fsm

Multicycle main control unit for the MIPS-subset core. Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select. It also drives the 4-bit ALUOp consumed by the ALU control unit directly downstream. Memory accesses stall on a single-bit ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from the cycle after ir_write
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory has completed current read/write
- ALUOp  out  4  to ALU control
  - 0000 R-type (decode funct)
  - 0001 add
  - 0010 sub
  - 0011 and
  - 0100 or
  - 0101 xor
  - 0110 slt
  - 0111 sltu
  - 1000 lui
- alu_src_a  out  1  0=PC, 1=A (rs)
- alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=sign-ext imm<<2
- ext_sel  out  1  0=sign-extend, 1=zero-extend imm
- pc_write  out  1  PC load enable
- pc_src  out  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],00}, 11=A
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  IR load
- reg_write  out  1  register file write
- reg_dst  out  2  00=rt, 01=rd, 10=$31
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- instr_done  out  1  1-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  1-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state, for debug

## Operation
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR, 6 R_EXEC
  - 7 R_WB, 8 BRANCH, 9 I_EXEC, 10 I_WB, 11 JUMP, 12 JAL, 13 JR
  - Codes 14-15 are unreachable; if entered, go to FETCH.
- Outputs are combinational from state, opcode, funct, zero and mem_ready. Any output not listed for a state is 0.
- FETCH
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOp=0001, pc_src=00.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold in FETCH with no writes.
- DECODE
  - Outputs: alu_src_a=0, alu_src_b=11, ALUOp=0001 (branch target into ALUOut).
  - Dispatch:
    - opcode 00 with funct 08 → JR; other funct → R_EXEC
    - 23, 2B → MEM_ADDR
    - 04, 05 → BRANCH
    - 08, 09, 0A, 0B, 0C, 0D, 0E, 0F → I_EXEC
    - 02 → JUMP; 03 → JAL
    - anything else: illegal_op=1, instr_done=1, go to FETCH
- MEM_ADDR
  - Outputs: alu_src_a=1, alu_src_b=10, ext_sel=0, ALUOp=0001.
  - Go to MEM_RD for lw (23), MEM_WR for sw (2B).
- MEM_RD: mem_read=1, iord=1; hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1 → FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready=1, then instr_done=1 → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, ALUOp=0000 → R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1 → FETCH.
- BRANCH
  - Outputs: alu_src_a=1, alu_src_b=00, ALUOp=0010, pc_src=01, instr_done=1 → FETCH.
  - pc_write = (opcode==04 & zero) | (opcode==05 & ~zero).
- I_EXEC
  - Outputs: alu_src_a=1, alu_src_b=10 → I_WB.
  - ALUOp by opcode: 08/09→0001, 0A→0110, 0B→0111, 0C→0011, 0D→0100, 0E→0101, 0F→1000.
  - ext_sel=1 for 0C/0D/0E, else 0.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1 → FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1 → FETCH.
- JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1 → FETCH.
  - $31 receives the pre-edge PC, i.e. PC+4.
- JR: pc_write=1, pc_src=11, instr_done=1 → FETCH.
- There are no delay slots.

## Timing
- Reset
  - rst=1 at a rising edge sets state=FETCH, regardless of current state or a pending mem_ready.
  - While rst=1, all enables and strobes (pc_write, ir_write, reg_write, mem_read, mem_write), instr_done and illegal_op are forced to 0.
  - While rst=1, every select output and ALUOp read 0.
  - The first cycle after release is FETCH.
- Latency with mem_ready tied to 1:
  - R-type 4, lw 5, sw 4, I-type 4 cycles
  - beq/bne, j, jal, jr 3 cycles; illegal opcode 2 cycles
- Each memory wait state adds 1 cycle.
- mem_ready is sampled only in FETCH, MEM_RD and MEM_WR; elsewhere it is ignored.
- Exactly one instr_done pulse is produced per instruction.

## Test plan
- rst held 3 cycles mid-MEM_RD with mem_ready=0 → all strobes 0 during reset; state=0 the cycle after release.
- add (op 00, funct 20), mem_ready=1 → states 0,1,6,7; ALUOp=0000 in R_EXEC; reg_write and instr_done in cycle 4 only.
- lw (23) with mem_ready low 2 cycles in both FETCH and MEM_RD → 9 cycles total; ir_write asserted only on the ready FETCH cycle; mem_to_reg=01 in MEM_WB.
- beq (04) with zero=1, then zero=0 → pc_write=1 with pc_src=01 in the first case; pc_write=0 in the second; 3 cycles each; bne gives the inverse.
- ori (0D) → ALUOp=0100, ext_sel=1, alu_src_b=10; lui (0F) → ALUOp=1000.
- jal (03) → cycle 3 has pc_write, reg_write, reg_dst=10, mem_to_reg=10; opcode 3F → illegal_op pulse in DECODE, back to FETCH.

Source files
------------

// File: rtl/main_ctrl_fsm_if.sv
// Control bus between the multicycle main control FSM and the datapath.
// Inputs to the FSM: opcode, funct, zero, mem_ready.
// Outputs from the FSM: ALUOp, mux selects, write enables, memory strobes, status pulses, debug state.
// master: the control FSM; slave: the datapath and memory side.
interface main_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] ALUOp;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ALUOp, alu_src_a, alu_src_b, ext_sel, pc_write, pc_src, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               instr_done, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ALUOp, alu_src_a, alu_src_b, ext_sel, pc_write, pc_src, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               instr_done, illegal_op, state
    );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS-subset main control: fetch/decode/execute/mem/writeback sequencing.
// Latency: R/sw/I-type 4, lw 5, branch/j/jal/jr 3, illegal 2 cycles; outputs combinational from state.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until mem_ready; mem_ready ignored elsewhere.
// Ports: clk, rst (sync, active-high), bus (main_ctrl_fsm_if.master) carrying all control signals.
module main_ctrl_fsm (
    input  logic                  clk,
    input  logic                  rst,
    main_ctrl_fsm_if.master       bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_RD = 4'd3,
        MEM_WB   = 4'd4,  MEM_WR = 4'd5,  R_EXEC   = 4'd6,  R_WB   = 4'd7,
        BRANCH   = 4'd8,  I_EXEC = 4'd9,  I_WB     = 4'd10, JUMP   = 4'd11,
        JAL      = 4'd12, JR     = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B, FN_JR   = 6'h08;

    localparam logic [3:0] ALU_RTYPE = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011, ALU_OR  = 4'b0100, ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110, ALU_SLTU = 4'b0111, ALU_LUI = 4'b1000;

    state_e state_q, state_d;

    logic [3:0] alu_op;
    logic       alu_src_a, ext_sel, pc_write, iord, mem_read, mem_write;
    logic       ir_write, reg_write, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = 4'b0000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_sel    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        // During reset every output stays at its zero default.
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_ADD;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    // Precompute the branch target into ALUOut while dispatching.
                    alu_src_b = 2'b11;
                    alu_op    = ALU_ADD;
                    case (bus.opcode)
                        OP_RTYPE:       state_d = (bus.funct == FN_JR) ? JR : R_EXEC;
                        OP_LW, OP_SW:   state_d = MEM_ADDR;
                        OP_BEQ, OP_BNE: state_d = BRANCH;
                        6'h08, 6'h09, 6'h0A, 6'h0B,
                        6'h0C, 6'h0D, 6'h0E, 6'h0F: state_d = I_EXEC;
                        OP_J:           state_d = JUMP;
                        OP_JAL:         state_d = JAL;
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_ADD;
                    state_d   = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (bus.mem_ready) state_d = MEM_WB;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (bus.mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_RTYPE;
                    state_d   = R_WB;
                end
                R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b01;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = 2'b01;
                    pc_write   = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                                 ((bus.opcode == OP_BNE) && !bus.zero);
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (bus.opcode)
                        6'h0A:   alu_op = ALU_SLT;
                        6'h0B:   alu_op = ALU_SLTU;
                        6'h0C:   alu_op = ALU_AND;
                        6'h0D:   alu_op = ALU_OR;
                        6'h0E:   alu_op = ALU_XOR;
                        6'h0F:   alu_op = ALU_LUI;
                        default: alu_op = ALU_ADD;
                    endcase
                    // Logical immediates zero-extend; arithmetic and compares sign-extend.
                    ext_sel = (bus.opcode == 6'h0C) || (bus.opcode == 6'h0D) ||
                              (bus.opcode == 6'h0E);
                    state_d = I_WB;
                end
                I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                JAL: begin
                    // PC already holds PC+4 from FETCH, so $31 gets the return address.
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                JR: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b11;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign bus.ALUOp      = alu_op;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ext_sel    = ext_sel;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.instr_done = instr_done;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed, table-driven bench for main_ctrl_fsm: each record is one cycle of inputs and expected outputs.
// Inputs are driven on the falling edge and outputs compared 1 time unit later, before the next rising edge.
module tb_main_ctrl_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    main_ctrl_fsm_if bus ();
    main_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] aluop;
        logic       sa;
        logic [1:0] sb;
        logic       ext;
        logic       pcw;
        logic [1:0] pcs;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       done;
        logic       ill;
    } out_t;

    typedef struct packed {
        logic       r;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        out_t       exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];
    vec_t rst_seq[$];

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic rdy, input logic [3:0] st,
                                input logic [3:0] aluop, input logic sa, input logic [1:0] sb,
                                input logic ext, input logic pcw, input logic [1:0] pcs,
                                input logic iord, input logic mr, input logic mw,
                                input logic irw, input logic rw, input logic [1:0] rd,
                                input logic [1:0] m2r, input logic done, input logic ill);
        vec_t v;
        v.r = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.exp = '{st, aluop, sa, sb, ext, pcw, pcs, iord, mr, mw, irw, rw, rd, m2r, done, ill};
        return v;
    endfunction

    // FETCH: mem_read, PC+4 through ALU; IR and PC load only when memory is ready.
    function automatic vec_t fetch(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                   input logic rdy);
        return mk(0, op, fn, z, rdy, 4'd0, 4'd1, 0, 2'd1, 0, rdy, 2'd0, 0, 1, 0, rdy, 0,
                  2'd0, 2'd0, 0, 0);
    endfunction

    // DECODE for a supported opcode: branch target PC + (imm<<2).
    function automatic vec_t dec(input logic [5:0] op, input logic [5:0] fn, input logic z);
        return mk(0, op, fn, z, 1, 4'd1, 4'd1, 0, 2'd3, 0, 0, 2'd0, 0, 0, 0, 0, 0,
                  2'd0, 2'd0, 0, 0);
    endfunction

    function automatic vec_t memaddr(input logic [5:0] op);
        return mk(0, op, 6'h00, 0, 1, 4'd2, 4'd1, 1, 2'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0,
                  2'd0, 2'd0, 0, 0);
    endfunction

    function automatic vec_t iexec(input logic [5:0] op, input logic [3:0] aluop,
                                   input logic ext);
        return mk(0, op, 6'h00, 0, 1, 4'd9, aluop, 1, 2'd2, ext, 0, 2'd0, 0, 0, 0, 0, 0,
                  2'd0, 2'd0, 0, 0);
    endfunction

    function automatic vec_t iwb(input logic [5:0] op);
        return mk(0, op, 6'h00, 0, 1, 4'd10, 4'd0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0, 1,
                  2'd0, 2'd0, 1, 0);
    endfunction

    function automatic vec_t branch(input logic [5:0] op, input logic z, input logic pcw);
        return mk(0, op, 6'h00, z, 1, 4'd8, 4'd2, 1, 2'd0, 0, pcw, 2'd1, 0, 0, 0, 0, 0,
                  2'd0, 2'd0, 1, 0);
    endfunction

    // Reset cycle: every output zero, state shows st.
    function automatic vec_t rcyc(input logic rdy, input logic [3:0] st);
        return mk(1, 6'h23, 6'h00, 0, rdy, st, 4'd0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0, 0,
                  2'd0, 2'd0, 0, 0);
    endfunction

    task automatic apply(input vec_t v, input string name, input int idx);
        out_t act;
        @(negedge clk);
        rst           = v.r;
        bus.opcode    = v.op;
        bus.funct     = v.fn;
        bus.zero      = v.z;
        bus.mem_ready = v.rdy;
        #1;
        act = '{bus.state, bus.ALUOp, bus.alu_src_a, bus.alu_src_b, bus.ext_sel,
                bus.pc_write, bus.pc_src, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.instr_done, bus.illegal_op};
        n_vec++;
        if (act !== v.exp) begin
            n_err++;
            $display("FAIL %s[%0d] op=%h fn=%h: got %h expected %h", name, idx, v.op, v.fn,
                     act, v.exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        tbl.push_back(rcyc(1, 4'd0));
        // add: 0,1,6,7
        tbl.push_back(fetch(6'h00, 6'h20, 0, 1));
        tbl.push_back(dec(6'h00, 6'h20, 0));
        tbl.push_back(mk(0, 6'h00, 6'h20, 0, 1, 4'd6, 4'd0, 1, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 6'h20, 0, 1, 4'd7, 4'd0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 1, 0));
        // lw with two wait cycles in FETCH and in MEM_RD: 9 cycles
        tbl.push_back(fetch(6'h23, 6'h00, 0, 0));
        tbl.push_back(fetch(6'h23, 6'h00, 0, 0));
        tbl.push_back(fetch(6'h23, 6'h00, 0, 1));
        tbl.push_back(dec(6'h23, 6'h00, 0));
        tbl.push_back(memaddr(6'h23));
        tbl.push_back(mk(0, 6'h23, 6'h00, 0, 0, 4'd3, 4'd0, 0, 2'd0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 6'h23, 6'h00, 0, 0, 4'd3, 4'd0, 0, 2'd0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 6'h23, 6'h00, 0, 1, 4'd3, 4'd0, 0, 2'd0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0));
        // MEM_WB with mem_ready low: ignored here
        tbl.push_back(mk(0, 6'h23, 6'h00, 0, 0, 4'd4, 4'd0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 1, 0));
        // sw with one wait in MEM_WR
        tbl.push_back(fetch(6'h2B, 6'h00, 0, 1));
        tbl.push_back(dec(6'h2B, 6'h00, 0));
        tbl.push_back(memaddr(6'h2B));
        tbl.push_back(mk(0, 6'h2B, 6'h00, 0, 0, 4'd5, 4'd0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 6'h2B, 6'h00, 0, 1, 4'd5, 4'd0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 1, 0));
        // beq taken / not taken, bne taken / not taken
        tbl.push_back(fetch(6'h04, 6'h00, 1, 1)); tbl.push_back(dec(6'h04, 6'h00, 1)); tbl.push_back(branch(6'h04, 1, 1));
        tbl.push_back(fetch(6'h04, 6'h00, 0, 1)); tbl.push_back(dec(6'h04, 6'h00, 0)); tbl.push_back(branch(6'h04, 0, 0));
        tbl.push_back(fetch(6'h05, 6'h00, 1, 1)); tbl.push_back(dec(6'h05, 6'h00, 1)); tbl.push_back(branch(6'h05, 1, 0));
        tbl.push_back(fetch(6'h05, 6'h00, 0, 1)); tbl.push_back(dec(6'h05, 6'h00, 0)); tbl.push_back(branch(6'h05, 0, 1));
        // ori, lui, sltiu, addi
        tbl.push_back(fetch(6'h0D, 6'h00, 0, 1)); tbl.push_back(dec(6'h0D, 6'h00, 0));
        tbl.push_back(iexec(6'h0D, 4'b0100, 1)); tbl.push_back(iwb(6'h0D));
        tbl.push_back(fetch(6'h0F, 6'h00, 0, 1)); tbl.push_back(dec(6'h0F, 6'h00, 0));
        tbl.push_back(iexec(6'h0F, 4'b1000, 0)); tbl.push_back(iwb(6'h0F));
        tbl.push_back(fetch(6'h0B, 6'h00, 0, 1)); tbl.push_back(dec(6'h0B, 6'h00, 0));
        tbl.push_back(iexec(6'h0B, 4'b0111, 0)); tbl.push_back(iwb(6'h0B));
        tbl.push_back(fetch(6'h08, 6'h00, 0, 1)); tbl.push_back(dec(6'h08, 6'h00, 0));
        tbl.push_back(iexec(6'h08, 4'b0001, 0)); tbl.push_back(iwb(6'h08));
        // j
        tbl.push_back(fetch(6'h02, 6'h00, 0, 1)); tbl.push_back(dec(6'h02, 6'h00, 0));
        tbl.push_back(mk(0, 6'h02, 6'h00, 0, 1, 4'd11, 4'd0, 0, 2'd0, 0, 1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0));
        // jal
        tbl.push_back(fetch(6'h03, 6'h00, 0, 1)); tbl.push_back(dec(6'h03, 6'h00, 0));
        tbl.push_back(mk(0, 6'h03, 6'h00, 0, 1, 4'd12, 4'd0, 0, 2'd0, 0, 1, 2'd2, 0, 0, 0, 0, 1, 2'd2, 2'd2, 1, 0));
        // jr (op 00, funct 08)
        tbl.push_back(fetch(6'h00, 6'h08, 0, 1)); tbl.push_back(dec(6'h00, 6'h08, 0));
        tbl.push_back(mk(0, 6'h00, 6'h08, 0, 1, 4'd13, 4'd0, 0, 2'd0, 0, 1, 2'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0));
        // illegal opcode 3F: pulse in DECODE, then back in FETCH
        tbl.push_back(fetch(6'h3F, 6'h00, 0, 1));
        tbl.push_back(mk(0, 6'h3F, 6'h00, 0, 1, 4'd1, 4'd1, 0, 2'd3, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1));
        tbl.push_back(fetch(6'h3F, 6'h00, 0, 0));

        foreach (tbl[i]) apply(tbl[i], "table", i);

        // Reset held 3 cycles in the middle of a stalled lw read.
        rst_seq.push_back(fetch(6'h23, 6'h00, 0, 1));
        rst_seq.push_back(dec(6'h23, 6'h00, 0));
        rst_seq.push_back(memaddr(6'h23));
        rst_seq.push_back(mk(0, 6'h23, 6'h00, 0, 0, 4'd3, 4'd0, 0, 2'd0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0));
        rst_seq.push_back(rcyc(0, 4'd3));
        rst_seq.push_back(rcyc(1, 4'd0));
        rst_seq.push_back(rcyc(0, 4'd0));
        rst_seq.push_back(fetch(6'h23, 6'h00, 0, 0));
        foreach (rst_seq[i]) apply(rst_seq[i], "mid_rd_reset", i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
